// File: rtl/duty_select.sv
// rtl/duty_select.sv - debounced 2-bit switch selects a PWM duty threshold,
// applied only at a PWM period boundary.
module duty_select #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [1:0] sw,
  input  logic       period_start,
  output logic [7:0] duty,
  output logic       duty_valid,
  output logic [1:0] sw_stable
);

  localparam logic [15:0] CNT_MAX    = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  DUTY_RESET = 8'd51;

  typedef enum logic {IDLE, PENDING} state_t;

  logic [1:0]  sw_meta;
  logic [1:0]  sw_sync;
  logic [1:0]  cand;
  logic [15:0] cnt;
  logic [7:0]  target;
  state_t      state;
  state_t      state_next;
  logic        load_duty;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sw_meta <= 2'b00;
      sw_sync <= 2'b00;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // Any disagreement restarts the count; cnt saturates so a held value keeps re-asserting.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cand      <= 2'b00;
      cnt       <= 16'd0;
      sw_stable <= 2'b00;
    end else if (sw_sync != cand) begin
      cand <= sw_sync;
      cnt  <= 16'd0;
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + 16'd1;
    end else begin
      sw_stable <= cand;
    end
  end

  always_comb begin
    target = DUTY_RESET;
    case (sw_stable)
      2'b00: target = 8'd51;
      2'b01: target = 8'd103;
      2'b10: target = 8'd154;
      2'b11: target = 8'd205;
      default: target = DUTY_RESET;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      duty       <= DUTY_RESET;
      duty_valid <= 1'b0;
    end else begin
      state      <= state_next;
      duty_valid <= load_duty;
      if (load_duty) duty <= target;
    end
  end

  // Loading uses the live target, so a switch that moves again while pending goes straight there.
  always_comb begin
    state_next = state;
    load_duty  = 1'b0;
    case (state)
      IDLE: begin
        if (target != duty) state_next = PENDING;
      end
      PENDING: begin
        if (target == duty) begin
          state_next = IDLE;
        end else if (period_start) begin
          load_duty  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_duty_select.sv
// tb/tb_duty_select.sv - scoreboard bench for duty_select with a short debounce interval.
module tb_duty_select;

  logic       sys_clk;
  logic       rst;
  logic [1:0] sw;
  logic       period_start;
  logic [7:0] duty;
  logic       duty_valid;
  logic [1:0] sw_stable;

  int checks;
  int failures;
  logic [7:0] sb[$];
  logic       prev_valid;

  duty_select #(.DEBOUNCE_CYCLES(4)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .sw          (sw),
    .period_start(period_start),
    .duty        (duty),
    .duty_valid  (duty_valid),
    .sw_stable   (sw_stable)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Every duty_valid pulse must match the oldest expected update.
  always @(negedge sys_clk) begin
    if (duty_valid) begin
      checks++;
      if (prev_valid) begin
        failures++;
        $display("FAIL valid_consecutive: duty_valid=%b two cycles in a row, required single pulse", duty_valid);
      end
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid: duty=%0d with duty_valid=1, required no update", duty);
      end else begin
        logic [7:0] exp_duty;
        exp_duty = sb.pop_front();
        if (duty !== exp_duty) begin
          failures++;
          $display("FAIL update_value: duty=%0d, required %0d", duty, exp_duty);
        end
      end
    end
    prev_valid = duty_valid;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic apply_reset();
    @(posedge sys_clk);
    #1;
    rst = 1'b1;
    sw = 2'b00;
    period_start = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pulse_period();
    @(posedge sys_clk);
    #1;
    period_start = 1'b1;
    @(posedge sys_clk);
    #1;
    period_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw = 2'b00;
    period_start = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    checks++;
    if (duty !== 8'd51) begin failures++; $display("FAIL reset_duty: duty=%0d, required 51", duty); end
    checks++;
    if (sw_stable !== 2'b00) begin failures++; $display("FAIL reset_stable: sw_stable=%b, required 00", sw_stable); end
    checks++;
    if (duty_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: duty_valid=%b, required 0", duty_valid); end
    rst = 1'b0;
    for (int p = 0; p < 3; p++) begin
      repeat (254) @(posedge sys_clk);
      pulse_period();
    end
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (duty !== 8'd51) begin failures++; $display("FAIL idle_duty: duty=%0d, required 51", duty); end
  endtask

  task automatic test_clean_change();
    apply_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    sw = 2'b10;
    @(posedge sys_clk);
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (sw_stable !== 2'b00) begin failures++; $display("FAIL clean_early: sw_stable=%b at N+5, required 00", sw_stable); end
    @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (sw_stable !== 2'b10) begin failures++; $display("FAIL clean_latency: sw_stable=%b at N+6, required 10", sw_stable); end
    repeat (10) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (duty !== 8'd51) begin failures++; $display("FAIL clean_hold: duty=%0d before period_start, required 51", duty); end
    sb.push_back(8'd154);
    pulse_period();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (duty !== 8'd154) begin failures++; $display("FAIL clean_duty: duty=%0d, required 154", duty); end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL clean_pulse: %0d updates outstanding, required 0", sb.size()); end
  endtask

  task automatic test_bounce();
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      @(posedge sys_clk);
      #1;
      sw = (((i / 3) % 2) == 0) ? 2'b01 : 2'b00;
      @(negedge sys_clk);
      checks++;
      if (sw_stable !== 2'b00) begin failures++; $display("FAIL bounce_stable: sw_stable=%b at step %0d, required 00", sw_stable, i); end
    end
    @(posedge sys_clk);
    #1;
    sw = 2'b01;
    @(posedge sys_clk);
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (sw_stable !== 2'b00) begin failures++; $display("FAIL bounce_early: sw_stable=%b at N+5, required 00", sw_stable); end
    @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (sw_stable !== 2'b01) begin failures++; $display("FAIL bounce_latency: sw_stable=%b at N+6, required 01", sw_stable); end
    repeat (2) @(posedge sys_clk);
    sb.push_back(8'd103);
    pulse_period();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (duty !== 8'd103) begin failures++; $display("FAIL bounce_duty: duty=%0d, required 103", duty); end
  endtask

  task automatic test_return();
    apply_reset();
    @(posedge sys_clk);
    #1;
    sw = 2'b11;
    repeat (8) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (sw_stable !== 2'b11) begin failures++; $display("FAIL return_stable11: sw_stable=%b, required 11", sw_stable); end
    @(posedge sys_clk);
    #1;
    sw = 2'b00;
    repeat (8) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (sw_stable !== 2'b00) begin failures++; $display("FAIL return_stable00: sw_stable=%b, required 00", sw_stable); end
    repeat (2) @(posedge sys_clk);
    pulse_period();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (duty !== 8'd51) begin failures++; $display("FAIL return_duty: duty=%0d, required 51", duty); end
  endtask

  task automatic test_redirect();
    apply_reset();
    @(posedge sys_clk);
    #1;
    sw = 2'b10;
    repeat (8) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (sw_stable !== 2'b10) begin failures++; $display("FAIL redirect_stable10: sw_stable=%b, required 10", sw_stable); end
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (duty !== 8'd51) begin failures++; $display("FAIL redirect_hold: duty=%0d, required 51", duty); end
    @(posedge sys_clk);
    #1;
    sw = 2'b11;
    repeat (8) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (sw_stable !== 2'b11) begin failures++; $display("FAIL redirect_stable11: sw_stable=%b, required 11", sw_stable); end
    sb.push_back(8'd205);
    pulse_period();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (duty !== 8'd205) begin failures++; $display("FAIL redirect_duty: duty=%0d, required 205", duty); end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL redirect_pulse: %0d updates outstanding, required 0", sb.size()); end
  endtask

  task automatic test_reset_pending();
    apply_reset();
    @(posedge sys_clk);
    #1;
    sw = 2'b11;
    repeat (10) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (sw_stable !== 2'b11) begin failures++; $display("FAIL rstpend_stable: sw_stable=%b, required 11", sw_stable); end
    @(posedge sys_clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (sw_stable !== 2'b00) begin failures++; $display("FAIL rstpend_async_stable: sw_stable=%b, required 00", sw_stable); end
    checks++;
    if (duty !== 8'd51 || duty_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstpend_async_duty: duty=%0d valid=%b, required 51 and 0", duty, duty_valid);
    end
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    pulse_period();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if (duty !== 8'd51) begin failures++; $display("FAIL rstpend_duty: duty=%0d, required 51", duty); end
    checks++;
    if (sw_stable !== 2'b00) begin failures++; $display("FAIL rstpend_credit: sw_stable=%b, required 00", sw_stable); end
    #1;
    sw = 2'b00;
    repeat (10) @(posedge sys_clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    prev_valid = 1'b0;
    test_reset();
    test_clean_change();
    test_bounce();
    test_return();
    test_redirect();
    test_reset_pending();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL final_queue: %0d updates outstanding, required 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
